adc_clock_divider_prog: RTL and testbench



---
 rtl/adc_clk_pkg.sv | 13 +
 rtl/adc_clock_divider_prog_if.sv | 29 ++
 rtl/adc_div_shadow_reg.sv | 72 +++++++
 rtl/adc_clock_divider_prog.sv | 98 +++++++++
 tb/tb_adc_clock_divider_prog.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_clk_pkg.sv
// Shared constants for the ADC clock/strobe divider.
//   MODE_TOGGLE / MODE_PULSE : output mode encodings
//   DEFAULT_DIV              : half-period divisor loaded at reset
//   DEFAULT_CNT_W            : default divisor/counter width
package adc_clk_pkg;

  localparam int unsigned DEFAULT_CNT_W = 16;
  localparam int unsigned DEFAULT_DIV   = 70;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/adc_clock_divider_prog_if.sv
// Control/status bundle of the ADC clock divider.
//   master : drives enable/div_load/div_in/mode_in, observes the divider outputs
//   slave  : the divider itself
interface adc_clock_divider_prog_if #(
  parameter int unsigned CNT_W = adc_clk_pkg::DEFAULT_CNT_W
);

  logic             enable;
  logic             div_load;
  logic [CNT_W-1:0] div_in;
  logic             mode_in;
  logic             clk_out;
  logic             tick_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] div_active;
  logic             update_pending;

  modport master (
    output enable, div_load, div_in, mode_in,
    input  clk_out, tick_out, rise_pulse, fall_pulse, div_active, update_pending
  );

  modport slave (
    input  enable, div_load, div_in, mode_in,
    output clk_out, tick_out, rise_pulse, fall_pulse, div_active, update_pending
  );

endinterface

// File: rtl/adc_div_shadow_reg.sv
// Double-buffered divisor/mode register.
//   clk, reset_Clock : clock, async active-high reset
//   load_i           : capture div_i/mode_i into the shadow
//   apply_i          : copy shadow into the active registers
//   div_active_o, mode_active_o : values in use by the divider
//   pending_o        : shadow holds a value not yet applied
module adc_div_shadow_reg #(
  parameter int unsigned CNT_W        = adc_clk_pkg::DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV  = adc_clk_pkg::DEFAULT_DIV,
  parameter logic        DEFAULT_MODE = adc_clk_pkg::MODE_TOGGLE
) (
  input  logic             clk,
  input  logic             reset_Clock,
  input  logic             load_i,
  input  logic             apply_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic [CNT_W-1:0] div_active_o,
  output logic             mode_active_o,
  output logic             pending_o
);

  import adc_clk_pkg::*;

  logic [CNT_W-1:0] sh_div_q,  sh_div_d;
  logic             sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic             act_mode_q, act_mode_d;
  logic             pend_q,    pend_d;

  // Shadow always equals the active value while nothing is pending, so an
  // unconditional copy on apply is harmless. A load on the apply edge wins
  // the pending flag and is applied at a later boundary.
  always_comb begin
    sh_div_d   = sh_div_q;
    sh_mode_d  = sh_mode_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    pend_d     = pend_q;
    if (apply_i) begin
      act_div_d  = sh_div_q;
      act_mode_d = sh_mode_q;
      pend_d     = 1'b0;
    end
    if (load_i) begin
      sh_div_d  = div_i;
      sh_mode_d = mode_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_Clock) begin
    if (reset_Clock) begin
      sh_div_q   <= CNT_W'(DEFAULT_DIV);
      sh_mode_q  <= DEFAULT_MODE;
      act_div_q  <= CNT_W'(DEFAULT_DIV);
      act_mode_q <= DEFAULT_MODE;
      pend_q     <= 1'b0;
    end else begin
      sh_div_q   <= sh_div_d;
      sh_mode_q  <= sh_mode_d;
      act_div_q  <= act_div_d;
      act_mode_q <= act_mode_d;
      pend_q     <= pend_d;
    end
  end

  assign div_active_o  = act_div_q;
  assign mode_active_o = act_mode_q;
  assign pending_o     = pend_q;

endmodule

// File: rtl/adc_clock_divider_prog.sv
// Programmable clock/strobe generator for the ADC interface.
//   clk, reset_Clock : system clock, async active-high reset
//   bus (slave)      : enable, div_load, div_in, mode_in in;
//                      clk_out, tick_out, rise_pulse, fall_pulse,
//                      div_active, update_pending out (all registered)
module adc_clock_divider_prog #(
  parameter int unsigned CNT_W        = adc_clk_pkg::DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV  = adc_clk_pkg::DEFAULT_DIV,
  parameter logic        DEFAULT_MODE = adc_clk_pkg::MODE_TOGGLE
) (
  input  logic                      clk,
  input  logic                      reset_Clock,
  adc_clock_divider_prog_if.slave   bus
);

  import adc_clk_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic [CNT_W-1:0] div_active;
  logic             mode_active;
  logic             pending;
  logic             wrap;
  logic             toggle_mode;
  logic             apply;

  assign wrap        = bus.enable && (cnt_q == div_active);
  assign toggle_mode = (mode_active == MODE_TOGGLE);
  // Period boundary: falling wrap in toggle mode, any wrap in pulse mode,
  // and every cycle while idle.
  assign apply       = !bus.enable || (wrap && (!toggle_mode || clk_out_q));

  adc_div_shadow_reg #(
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_MODE (DEFAULT_MODE)
  ) u_shadow (
    .clk           (clk),
    .reset_Clock   (reset_Clock),
    .load_i        (bus.div_load),
    .apply_i       (apply),
    .div_i         (bus.div_in),
    .mode_i        (bus.mode_in),
    .div_active_o  (div_active),
    .mode_active_o (mode_active),
    .pending_o     (pending)
  );

  // Counter, divided clock and edge markers; disable is a forced stop.
  always_comb begin
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (bus.enable) begin
      if (wrap) begin
        tick_d = 1'b1;
        if (toggle_mode) begin
          clk_out_d = !clk_out_q;
          rise_d    = !clk_out_q;
          fall_d    = clk_out_q;
        end
      end else begin
        cnt_d     = cnt_q + CNT_W'(1);
        clk_out_d = toggle_mode && clk_out_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_Clock) begin
    if (reset_Clock) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign bus.clk_out        = clk_out_q;
  assign bus.tick_out       = tick_q;
  assign bus.rise_pulse     = rise_q;
  assign bus.fall_pulse     = fall_q;
  assign bus.div_active     = div_active;
  assign bus.update_pending = pending;

endmodule

// File: tb/tb_adc_clock_divider_prog.sv
// Directed + randomized bench for adc_clock_divider_prog with a
// behavioural reference model (segment-length view of the divider).
module tb_adc_clock_divider_prog;

  logic clk = 1'b0;
  logic reset_Clock = 1'b1;

  adc_clock_divider_prog_if #(.CNT_W(16)) bus ();

  adc_clock_divider_prog #(
    .CNT_W        (16),
    .DEFAULT_DIV  (70),
    .DEFAULT_MODE (1'b0)
  ) dut (
    .clk         (clk),
    .reset_Clock (reset_Clock),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: a segment is H+1 enabled cycles long.
  int unsigned m_seg, m_div, m_sh_div;
  bit m_mode, m_sh_mode, m_pend;
  bit m_clk, m_tick, m_rise, m_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_div = 70; m_mode = 1'b0;
    m_sh_div = 70; m_sh_mode = 1'b0; m_pend = 1'b0;
    m_clk = 1'b0; m_tick = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int unsigned din, input bit md);
    bit seg_end, boundary;
    seg_end = 1'b0;
    if (en) begin
      m_seg++;
      if (m_seg > m_div) begin
        seg_end = 1'b1;
        m_seg = 0;
      end
    end else begin
      m_seg = 0;
    end
    m_tick   = seg_end;
    m_rise   = seg_end && !m_mode && !m_clk;
    m_fall   = seg_end && !m_mode && m_clk;
    boundary = !en || (seg_end && (m_mode || m_clk));
    if (!en || m_mode) m_clk = 1'b0;
    else if (seg_end)  m_clk = !m_clk;
    if (boundary) begin
      m_div = m_sh_div; m_mode = m_sh_mode; m_pend = 1'b0;
    end
    if (ld) begin
      m_sh_div = din; m_sh_mode = md; m_pend = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("clk_out",        32'(bus.clk_out),        32'(m_clk));
    chk("tick_out",       32'(bus.tick_out),       32'(m_tick));
    chk("rise_pulse",     32'(bus.rise_pulse),     32'(m_rise));
    chk("fall_pulse",     32'(bus.fall_pulse),     32'(m_fall));
    chk("div_active",     32'(bus.div_active),     m_div);
    chk("update_pending", 32'(bus.update_pending), 32'(m_pend));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(bus.enable, bus.div_load, 32'(bus.div_in), bus.mode_in);
    #1;
    check_all();
  endtask

  task automatic load(input int unsigned d, input bit m);
    bus.div_load = 1'b1;
    bus.div_in   = 16'(d);
    bus.mode_in  = m;
    cyc();
    bus.div_load = 1'b0;
  endtask

  // sel: 0 rise_pulse, 1 fall_pulse, 2 tick_out, 3 update_pending low
  task automatic run_until(input int sel, input int bound, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < bound) begin
      cyc();
      n++;
      case (sel)
        0:       found = bus.rise_pulse;
        1:       found = bus.fall_pulse;
        2:       found = bus.tick_out;
        default: found = !bus.update_pending;
      endcase
    end
    nvec++;
    assert (found === 1'b1) else begin
      nerr++;
      $error("FAIL timeout sel=%0d: observed %0d cycles without event, expected event within %0d", sel, n, bound);
    end
  endtask

  initial begin
    int n, ticks, highs;
    bus.enable = 1'b1;
    bus.div_load = 1'b0;
    bus.div_in = '0;
    bus.mode_in = 1'b0;
    model_reset();

    // Reset values
    @(posedge clk);
    #1;
    check_all();
    chk("rst_div_active", 32'(bus.div_active), 32'd70);
    reset_Clock = 1'b0;

    // Defaults: rise at 71, fall at 142, rise at 213
    run_until(0, 200, n); chk("first_rise", n, 71);
    chk("clk_high_at_rise", 32'(bus.clk_out), 32'd1);
    run_until(1, 200, n); chk("first_fall", n, 71);
    run_until(0, 200, n); chk("second_rise", n, 71);

    // Back-to-back loads (5 then 0): last wins, applied at falling boundary
    bus.div_load = 1'b1; bus.div_in = 16'd5; bus.mode_in = 1'b0;
    cyc();
    bus.div_in = 16'd0;
    cyc();
    bus.div_load = 1'b0;
    chk("b2b_pending", 32'(bus.update_pending), 32'd1);
    run_until(1, 200, n); chk("h0_apply_fall", n, 69);
    chk("h0_div_active", 32'(bus.div_active), 32'd0);
    chk("h0_pending_clr", 32'(bus.update_pending), 32'd0);
    run_until(0, 10, n); chk("h0_rise_gap", n, 1);
    run_until(1, 10, n); chk("h0_fall_gap", n, 1);

    // Pulse mode H=4
    load(4, 1'b1);
    run_until(3, 20, n); chk("pulse_apply", n, 1);
    chk("pulse_div_active", 32'(bus.div_active), 32'd4);
    ticks = 0; highs = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      ticks += int'(bus.tick_out);
      highs += int'(bus.clk_out) + int'(bus.rise_pulse) + int'(bus.fall_pulse);
    end
    chk("pulse_ticks", ticks, 10);
    chk("pulse_clk_quiet", highs, 0);

    // Back to toggle H=70 at a pulse wrap, then reload H=10 mid high phase
    load(70, 1'b0);
    run_until(3, 20, n); chk("p2t_apply", n, 4);
    chk("p2t_clk_low", 32'(bus.clk_out), 32'd0);
    run_until(0, 200, n); chk("p2t_rise", n, 71);
    for (int i = 0; i < 30; i++) cyc();
    load(10, 1'b0);
    chk("h10_pending", 32'(bus.update_pending), 32'd1);
    run_until(1, 200, n); chk("h10_fall", n, 40);
    chk("h10_div_active", 32'(bus.div_active), 32'd10);
    chk("h10_pending_clr", 32'(bus.update_pending), 32'd0);
    run_until(0, 50, n); chk("h10_rise", n, 11);
    run_until(1, 50, n); chk("h10_fall2", n, 11);

    // Disable while clk_out=1 at counter 40
    load(70, 1'b0);
    run_until(3, 50, n); chk("h70_apply", n, 21);
    run_until(0, 200, n); chk("h70_rise", n, 71);
    for (int i = 0; i < 40; i++) cyc();
    bus.enable = 1'b0;
    cyc();
    chk("dis_clk", 32'(bus.clk_out), 32'd0);
    chk("dis_fall", 32'(bus.fall_pulse), 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    load(5, 1'b0);
    chk("idle_pending", 32'(bus.update_pending), 32'd1);
    cyc();
    chk("idle_apply_div", 32'(bus.div_active), 32'd5);
    chk("idle_apply_pend", 32'(bus.update_pending), 32'd0);
    bus.enable = 1'b1;
    run_until(0, 50, n); chk("reen_rise", n, 6);

    // Async reset with a pending update
    load(9, 1'b0);
    chk("prerst_pending", 32'(bus.update_pending), 32'd1);
    #2 reset_Clock = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset_Clock = 1'b0;
    run_until(0, 200, n); chk("postrst_rise", n, 71);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.enable   = ($urandom_range(0, 15) != 0);
      bus.div_load = ($urandom_range(0, 7) == 0);
      bus.div_in   = 16'($urandom_range(0, 12));
      bus.mode_in  = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.div_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
